// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter.
//   arb_state_t     : arbiter FSM state (ARB_IDLE = no grant, ARB_BUSY = grant held)
//   ARB_TIMEOUT_DEF : default maximum grant length in cycles (used only when
//                     ARB_TIMEOUT_EN is defined)
package arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   localparam int ARB_TIMEOUT_DEF = 16;

endpackage

// File: rtl/rr_arbiter_if.sv
// Handshake bundle between requesters and the round-robin arbiter.
//   req_i      : level request vector, bit i = requester i
//   done_i     : release pulse from the granted requester
//   gnt_o      : registered one-hot grant, zero when idle
//   gnt_idx_o  : binary index of the granted requester (valid with gnt_val_o)
//   gnt_val_o  : high while a grant is held
//   timeout_o  : one-cycle pulse when a grant is force-revoked
// Modports: slave = arbiter side, master = requester side.
interface rr_arbiter_if #(
   parameter int WIDTH = 4
) ();

   localparam int IW = $clog2(WIDTH);

   logic [WIDTH-1:0] req_i;
   logic             done_i;
   logic [WIDTH-1:0] gnt_o;
   logic [IW-1:0]    gnt_idx_o;
   logic             gnt_val_o;
   logic             timeout_o;

   modport slave (
      input  req_i,
      input  done_i,
      output gnt_o,
      output gnt_idx_o,
      output gnt_val_o,
      output timeout_o
   );

   modport master (
      output req_i,
      output done_i,
      input  gnt_o,
      input  gnt_idx_o,
      input  gnt_val_o,
      input  timeout_o
   );

endinterface

// File: rtl/rr_pick.sv
// Rotating first-set-bit search: finds the first set bit of req scanning
// upward from ptr and wrapping modulo WIDTH. Purely combinational.
//   req    : request vector
//   ptr    : starting position of the scan
//   onehot : one-hot winner (zero if no request)
//   idx    : binary winner index (zero if no request)
//   any    : at least one request is set
module rr_pick #(
   parameter int WIDTH = 4,
   localparam int IW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [WIDTH-1:0] onehot,
   output logic [IW-1:0]    idx,
   output logic             any
);

   int pos;

   // Walk the offsets from farthest to nearest so the nearest set bit is the
   // last one written and therefore wins.
   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = |req;
      pos    = 0;
      for (int k = WIDTH - 1; k >= 0; k--) begin
         pos = int'(ptr) + k;
         if (pos >= WIDTH) pos = pos - WIDTH;
         if (req[pos]) begin
            onehot      = '0;
            onehot[pos] = 1'b1;
            idx         = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant held until released.
//   clk_i  : clock, rising edge
//   srst_i : synchronous active-high reset
//   bus    : rr_arbiter_if.slave (req_i, done_i in; gnt_o, gnt_idx_o,
//            gnt_val_o, timeout_o out)
// Optional feature: define ARB_TIMEOUT_EN to bound each grant to TIMEOUT
// cycles; a force-revoked grant pulses timeout_o. Without the macro no
// counter exists and timeout_o is tied low.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
   input  logic         clk_i,
   input  logic         srst_i,
   rr_arbiter_if.slave  bus
);

   localparam int IW = $clog2(WIDTH);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("rr_arbiter: WIDTH must be 2..32");
   end
   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("rr_arbiter: TIMEOUT must be >= 2");
   end

   arb_state_t       state, state_n;
   logic [IW-1:0]    ptr, ptr_n;
   logic [IW-1:0]    idx, idx_n;
   logic [WIDTH-1:0] gnt, gnt_n;
   logic             val, val_n;

   logic [IW-1:0]    after_idx;   // position just past the current holder
   logic [IW-1:0]    pick_ptr;
   logic [WIDTH-1:0] pick_oh;
   logic [IW-1:0]    pick_idx;
   logic             pick_any;
   logic             expire;      // grant is being force-revoked this cycle
   logic             load;        // a new grant is issued at the next edge

   assign after_idx = (idx == IW'(WIDTH - 1)) ? '0 : idx + IW'(1);

   // While busy the only search that matters is the one at release, which
   // must already use the advanced pointer so the holder goes to the back.
   assign pick_ptr = (state == ARB_BUSY) ? after_idx : ptr;

   rr_pick #(.WIDTH(WIDTH)) u_pick (
      .req    (bus.req_i),
      .ptr    (pick_ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      idx_n   = idx;
      gnt_n   = gnt;
      val_n   = val;
      load    = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (pick_any) begin
               state_n = ARB_BUSY;
               gnt_n   = pick_oh;
               idx_n   = pick_idx;
               val_n   = 1'b1;
               load    = 1'b1;
            end
         end
         ARB_BUSY: begin
            if (bus.done_i || expire) begin
               ptr_n = after_idx;
               if (pick_any) begin
                  gnt_n = pick_oh;
                  idx_n = pick_idx;
                  load  = 1'b1;
               end else begin
                  state_n = ARB_IDLE;
                  gnt_n   = '0;
                  idx_n   = '0;
                  val_n   = 1'b0;
               end
            end
         end
         default: state_n = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state <= ARB_IDLE;
         ptr   <= '0;
         idx   <= '0;
         gnt   <= '0;
         val   <= 1'b0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         idx   <= idx_n;
         gnt   <= gnt_n;
         val   <= val_n;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt, cnt_n;
   logic          tmo;

   // A done_i arriving on the last allowed cycle wins: it is a normal release.
   assign expire = (state == ARB_BUSY) && !bus.done_i && (cnt == CW'(TIMEOUT - 1));

   // Counter never passes TIMEOUT-1: at that value the grant is released.
   always_comb begin
      cnt_n = cnt;
      if (load)                   cnt_n = '0;
      else if (state == ARB_BUSY) cnt_n = cnt + CW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         cnt <= '0;
         tmo <= 1'b0;
      end else begin
         cnt <= cnt_n;
         tmo <= expire;
      end
   end

   assign bus.timeout_o = tmo;
`else
   assign expire        = 1'b0;
   assign bus.timeout_o = 1'b0;
`endif

   assign bus.gnt_o     = gnt;
   assign bus.gnt_idx_o = idx;
   assign bus.gnt_val_o = val;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (WIDTH=4, TIMEOUT=8): a directed vector
// table, hand-written timeout sequences, then randomized traffic compared
// against a behavioural reference model. Works with or without ARB_TIMEOUT_EN.
module tb_rr_arbiter;

   localparam int W   = 4;
   localparam int TMO = 8;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk  = 1'b0;
   logic srst = 1'b0;

   rr_arbiter_if #(.WIDTH(W)) bus ();

   rr_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
      .clk_i  (clk),
      .srst_i (srst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic [3:0] r, input logic d, input logic s);
      bus.req_i  = r;
      bus.done_i = d;
      srst       = s;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string name, input logic [3:0] g, input int i,
                          input logic v, input logic t);
      chk({name, ".gnt"}, 32'(bus.gnt_o), 32'(g));
      chk({name, ".val"}, 32'(bus.gnt_val_o), 32'(v));
      chk({name, ".tmo"}, 32'(bus.timeout_o), 32'(t));
      if (v) chk({name, ".idx"}, 32'(bus.gnt_idx_o), 32'(i));
   endtask

   // ---------------- reference model ----------------
   bit m_busy;
   int m_ptr, m_idx, m_cnt;
   bit m_to;

   function automatic int first_from(input logic [3:0] r, input int start);
      for (int k = 0; k < W; k++)
         if (r[(start + k) % W]) return (start + k) % W;
      return -1;
   endfunction

   task automatic model_step(input logic [3:0] r, input logic d, input logic s);
      int w;
      bit exp_to;
      m_to = 1'b0;
      if (s) begin
         m_busy = 0; m_ptr = 0; m_idx = 0; m_cnt = 0;
      end else if (!m_busy) begin
         w = first_from(r, m_ptr);
         if (w >= 0) begin m_busy = 1; m_idx = w; m_cnt = 0; end
      end else begin
         exp_to = TO_EN && (m_cnt == TMO - 1) && !d;
         if (d || exp_to) begin
            m_ptr = (m_idx + 1) % W;
            m_to  = exp_to;
            w = first_from(r, m_ptr);
            if (w >= 0) begin m_idx = w; m_cnt = 0; end
            else begin m_busy = 0; m_idx = 0; end
         end else begin
            m_cnt++;
         end
      end
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [3:0] req;
      logic       done;
      logic       rst;
      logic [3:0] gnt;
      int         idx;
      logic       val;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [3:0] r, input logic d, input logic s,
                      input logic [3:0] g, input int i, input logic v);
      vec_t e;
      e = '{req: r, done: d, rst: s, gnt: g, idx: i, val: v};
      tbl.push_back(e);
   endtask

   initial begin
      logic [3:0] r;
      logic       d, s;

      bus.req_i  = '0;
      bus.done_i = 1'b0;

      //  req      done rst  gnt      idx val
      add(4'b0000, 0,   1,   4'b0000, 0,  0);   // reset state
      add(4'b0110, 0,   0,   4'b0010, 1,  1);   // first grant from ptr 0
      add(4'b0110, 1,   0,   4'b0100, 2,  1);   // release -> next upward
      add(4'b0000, 0,   1,   4'b0000, 0,  0);
      add(4'b1111, 0,   0,   4'b0001, 0,  1);   // rotation 0,1,2,3,0
      add(4'b1111, 1,   0,   4'b0010, 1,  1);
      add(4'b1111, 1,   0,   4'b0100, 2,  1);
      add(4'b1111, 1,   0,   4'b1000, 3,  1);
      add(4'b1111, 1,   0,   4'b0001, 0,  1);
      add(4'b1111, 0,   0,   4'b0001, 0,  1);   // held without done
      add(4'b0001, 1,   0,   4'b0001, 0,  1);   // sole requester re-granted
      add(4'b0000, 1,   0,   4'b0000, 0,  0);   // release, nobody waiting
      add(4'b0100, 0,   0,   4'b0100, 2,  1);   // grant 2
      for (int k = 0; k < 5; k++)
         add(4'b0000, 0, 0, 4'b0100, 2, 1);     // dropped req keeps grant
      add(4'b0000, 1,   0,   4'b0000, 0,  0);   // ptr now 3
      add(4'b0010, 0,   0,   4'b0010, 1,  1);   // scan 3,0,1 -> 1
      add(4'b1111, 1,   1,   4'b0000, 0,  0);   // reset beats done/req
      add(4'b1000, 0,   0,   4'b1000, 3,  1);   // ptr back at 0 -> 3
      add(4'b1000, 1,   0,   4'b1000, 3,  1);
      add(4'b0000, 1,   0,   4'b0000, 0,  0);
      add(4'b0000, 1,   0,   4'b0000, 0,  0);   // done in idle ignored
      add(4'b0001, 0,   0,   4'b0001, 0,  1);

      foreach (tbl[n]) begin
         step(tbl[n].req, tbl[n].done, tbl[n].rst);
         chk_out($sformatf("vec%0d", n), tbl[n].gnt, tbl[n].idx, tbl[n].val, 1'b0);
      end

      // ---- timeout with another requester waiting ----
      step(4'b0000, 0, 1);
      step(4'b0011, 0, 0);
      chk_out("to_grant", 4'b0001, 0, 1, 0);
      for (int k = 1; k < TMO; k++) begin
         step(4'b0011, 0, 0);
         chk_out($sformatf("to_hold%0d", k), 4'b0001, 0, 1, 0);
      end
      step(4'b0011, 0, 0);
      if (TO_EN) chk_out("to_fire", 4'b0010, 1, 1, 1);
      else       chk_out("to_fire", 4'b0001, 0, 1, 0);
      step(4'b0011, 0, 0);
      if (TO_EN) chk_out("to_pulse_end", 4'b0010, 1, 1, 0);
      else       chk_out("to_pulse_end", 4'b0001, 0, 1, 0);
      for (int k = 0; k < TMO - 2; k++) step(4'b0011, 0, 0);
      step(4'b0011, 1, 0);                      // done on the last allowed cycle
      if (TO_EN) chk_out("to_done_last", 4'b0001, 0, 1, 0);
      else       chk_out("to_done_last", 4'b0010, 1, 1, 0);

      // ---- timeout with nobody waiting clears the grant ----
      step(4'b0000, 0, 1);
      step(4'b0100, 0, 0);
      chk_out("toc_grant", 4'b0100, 2, 1, 0);
      for (int k = 1; k < TMO; k++) step(4'b0000, 0, 0);
      step(4'b0000, 0, 0);
      if (TO_EN) chk_out("toc_fire", 4'b0000, 0, 0, 1);
      else       chk_out("toc_fire", 4'b0100, 2, 1, 0);
      step(4'b0000, 0, 0);
      if (TO_EN) chk_out("toc_after", 4'b0000, 0, 0, 0);
      else       chk_out("toc_after", 4'b0100, 2, 1, 0);

      // ---- randomized traffic vs. reference model ----
      step(4'b0000, 0, 1);
      model_step(4'b0000, 0, 1);
      for (int n = 0; n < 800; n++) begin
         r = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
         d = (n < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         s = ($urandom_range(0, 63) == 0);
         step(r, d, s);
         model_step(r, d, s);
         chk_out($sformatf("rnd%0d", n), m_busy ? 4'(1 << m_idx) : 4'b0000,
                 m_idx, m_busy, m_to);
         chk($sformatf("rnd%0d.onehot", n), 32'($onehot0(bus.gnt_o)), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, number of requesters; legal range 2..32.
REQ-002 Parameter TIMEOUT, default 16, maximum grant length in cycles; only used when ARB_TIMEOUT_EN is defined; legal range ≥2.
REQ-003 clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 srst_i  input  1  reset, synchronous, active-high.
REQ-005 req_i  input  WIDTH  request vector; bit i is requester i's level request.
REQ-006 done_i  input  1  resource-release pulse from the granted requester.
REQ-007 gnt_o  output  WIDTH  registered one-hot grant, all-zero when idle.
REQ-008 gnt_idx_o  output  $clog2(WIDTH)  binary index of the granted requester; valid only while gnt_val_o=1.
REQ-009 gnt_val_o  output  1  high while any grant is held.
REQ-010 timeout_o  output  1  one-cycle pulse when a grant is force-revoked.

Function
REQ-011 FSM has two states: IDLE (no grant) and BUSY (grant held).
REQ-012 IDLE: if req_i != 0, the winner is the first set bit scanning upward from pointer ptr, wrapping modulo WIDTH; gnt_o/gnt_idx_o/gnt_val_o update on the next edge (latency 1); go to BUSY.
REQ-013 IDLE with req_i == 0: outputs stay zero, ptr unchanged.
REQ-014 BUSY: grant held constant until release; a dropped req_i bit of the winner does not release the grant.
REQ-015 Release = done_i high in BUSY; after release ptr = (gnt_idx_o + 1) mod WIDTH.
REQ-016 At release, if req_i has any bit set, the next winner is selected with the updated ptr and granted on the next edge (back-to-back, state stays BUSY); otherwise outputs go to zero next edge and state goes IDLE.
REQ-017 The just-released requester wins back-to-back only if it is the sole requester.
REQ-018 done_i in IDLE is ignored.
REQ-019 gnt_o is always one-hot or zero; gnt_o == (1 << gnt_idx_o) whenever gnt_val_o=1.
REQ-020 timeout_o is zero whenever ARB_TIMEOUT_EN is not defined.

Reset
REQ-021 srst_i=1 sets on next edge: state IDLE, ptr 0, gnt_o 0, gnt_idx_o 0, gnt_val_o 0, timeout_o 0, timeout counter 0.
REQ-022 srst_i during BUSY drops the grant on the next edge with no timeout_o pulse; srst_i overrides done_i and req_i.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN: when defined, a counter clears on every new grant and increments each BUSY cycle; if it reaches TIMEOUT-1 without done_i, the grant is released as per REQ-015/REQ-016 and timeout_o pulses for exactly one cycle, coincident with the edge that removes or replaces the grant.
REQ-024 done_i in the same cycle the counter hits TIMEOUT-1 is a normal release; no timeout_o pulse.
REQ-025 Without ARB_TIMEOUT_EN, no counter is synthesized, grants are unbounded, and timeout_o is tied 0.

Structure
REQ-026 Package arb_pkg holds the state enum typedef (ARB_IDLE, ARB_BUSY) and the default TIMEOUT constant.
REQ-027 The rotating first-set-bit search is a combinational sub-module rr_pick (inputs req vector and ptr, outputs one-hot, index, any-valid), instantiated once.

Verification (WIDTH=4, TIMEOUT=8)
REQ-028 Reset, then req_i=4'b0110 -> next cycle gnt_o=4'b0010, gnt_idx_o=1, gnt_val_o=1.
REQ-029 Hold req_i=4'b1111; pulse done_i after each grant -> grant order 0,1,2,3,0, with each handover occurring on the edge after done_i.
REQ-030 req_i=4'b0001 only, pulse done_i -> requester 0 re-granted back-to-back; then req_i=0 plus done_i -> gnt_val_o=0 next cycle.
REQ-031 Grant requester 2, deassert req_i[2] without done_i for 5 cycles -> gnt_o stays 4'b0100.
REQ-032 ARB_TIMEOUT_EN defined, grant held with no done_i -> after 8 BUSY cycles timeout_o pulses once, grant moves to the next requester or clears; without the macro the grant persists and timeout_o=0.
REQ-033 srst_i asserted in BUSY with done_i=1 -> next cycle all outputs 0; the next request from 4'b1000 is granted per ptr=0 (index 3).
